// File: rtl/map_tile_renderer.sv
// Tile renderer: walks the grid store and paints each cell as a TILE_W x TILE_H block
// of its palette colour through the vga_adapter plot interface (full map or one cell).
module map_tile_renderer #(
   parameter int GRID_W   = 20,
   parameter int GRID_H   = 15,
   parameter int TILE_W   = 8,
   parameter int TILE_H   = 8,
   parameter int CELL_W   = 2,
   parameter int COLOUR_W = 3,
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int X_OFF    = 0,
   parameter int Y_OFF    = 0,
   localparam int GX_W    = $clog2(GRID_W),
   localparam int GY_W    = $clog2(GRID_H),
   localparam int PAL_W   = COLOUR_W * (2 ** CELL_W)
) (
   input  logic                clock_50,
   input  logic                resetn,
   input  logic                start,
   input  logic                single,
   input  logic [GX_W-1:0]     req_x,
   input  logic [GY_W-1:0]     req_y,
   input  logic [PAL_W-1:0]    palette,
   output logic [GX_W-1:0]     grid_x,
   output logic [GY_W-1:0]     grid_y,
   output logic                grid_rd,
   input  logic [CELL_W-1:0]   grid_data,
   output logic [X_W-1:0]      vga_x,
   output logic [Y_W-1:0]      vga_y,
   output logic [COLOUR_W-1:0] colour,
   output logic                vga_plot,
   output logic                busy,
   output logic                done
);

   localparam int PX_W = (TILE_W > 1) ? $clog2(TILE_W) : 1;
   localparam int PY_W = (TILE_H > 1) ? $clog2(TILE_H) : 1;
   localparam int N_COL = 2 ** CELL_W;

   localparam logic [GX_W:0]     GRID_W_E = (GX_W + 1)'(GRID_W);
   localparam logic [GY_W:0]     GRID_H_E = (GY_W + 1)'(GRID_H);
   localparam logic [GX_W-1:0]   CX_LAST  = GX_W'(GRID_W - 1);
   localparam logic [GY_W-1:0]   CY_LAST  = GY_W'(GRID_H - 1);
   localparam logic [PX_W-1:0]   PX_LAST  = PX_W'(TILE_W - 1);
   localparam logic [PY_W-1:0]   PY_LAST  = PY_W'(TILE_H - 1);
   localparam logic [GX_W-1:0]   CX_ONE   = GX_W'(1);
   localparam logic [GY_W-1:0]   CY_ONE   = GY_W'(1);
   localparam logic [PX_W-1:0]   PX_ONE   = PX_W'(1);
   localparam logic [PY_W-1:0]   PY_ONE   = PY_W'(1);
   localparam logic [X_W-1:0]    X_OFF_C  = X_W'(X_OFF);
   localparam logic [Y_W-1:0]    Y_OFF_C  = Y_W'(Y_OFF);
   localparam logic [X_W-1:0]    TILE_W_C = X_W'(TILE_W);
   localparam logic [Y_W-1:0]    TILE_H_C = Y_W'(TILE_H);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_DRAW  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   function automatic logic [COLOUR_W-1:0] pal_lookup(input logic [PAL_W-1:0] pal,
                                                       input logic [CELL_W-1:0] code);
      logic [COLOUR_W-1:0] c;
      c = '0;
      for (int k = 0; k < N_COL; k++) begin
         c = (code == CELL_W'(k)) ? pal[k*COLOUR_W +: COLOUR_W] : c;
      end
      return c;
   endfunction

   function automatic logic [X_W-1:0] pix_x(input logic [GX_W-1:0] cx, input logic [PX_W-1:0] px);
      return X_OFF_C + X_W'(cx) * TILE_W_C + X_W'(px);
   endfunction

   function automatic logic [Y_W-1:0] pix_y(input logic [GY_W-1:0] cy, input logic [PY_W-1:0] py);
      return Y_OFF_C + Y_W'(cy) * TILE_H_C + Y_W'(py);
   endfunction

   state_t              state_q, state_d;
   logic                single_q, single_d;
   logic [GX_W-1:0]     cx_q, cx_d;
   logic [GY_W-1:0]     cy_q, cy_d;
   logic [PX_W-1:0]     px_q, px_d;
   logic [PY_W-1:0]     py_q, py_d;
   logic [GX_W-1:0]     grid_x_q, grid_x_d;
   logic [GY_W-1:0]     grid_y_q, grid_y_d;
   logic                grid_rd_q, grid_rd_d;
   logic [X_W-1:0]      vga_x_q, vga_x_d;
   logic [Y_W-1:0]      vga_y_q, vga_y_d;
   logic [COLOUR_W-1:0] colour_q, colour_d;
   logic                vga_plot_q, vga_plot_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                req_bad_s;
   logic                tile_end_s;
   logic                frame_end_s;

   // Outputs are computed for the state being entered so they line up with it.
   always_comb begin
      state_d    = state_q;
      single_d   = single_q;
      cx_d       = cx_q;
      cy_d       = cy_q;
      px_d       = px_q;
      py_d       = py_q;
      grid_x_d   = grid_x_q;
      grid_y_d   = grid_y_q;
      grid_rd_d  = 1'b0;
      vga_x_d    = vga_x_q;
      vga_y_d    = vga_y_q;
      colour_d   = colour_q;
      vga_plot_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;

      req_bad_s   = ({1'b0, req_x} >= GRID_W_E) || ({1'b0, req_y} >= GRID_H_E);
      tile_end_s  = (px_q == PX_LAST) && (py_q == PY_LAST);
      frame_end_s = single_q || ((cx_q == CX_LAST) && (cy_q == CY_LAST));

      case (state_q)
         S_IDLE: begin
            if (start) begin
               single_d = single;
               if (single && req_bad_s) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  cx_d      = single ? req_x : '0;
                  cy_d      = single ? req_y : '0;
                  state_d   = S_FETCH;
                  grid_rd_d = 1'b1;
                  grid_x_d  = cx_d;
                  grid_y_d  = cy_d;
                  busy_d    = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            state_d = S_WAIT;
            busy_d  = 1'b1;
         end
         S_WAIT: begin
            // grid_data answers the read issued in FETCH during this cycle.
            colour_d   = pal_lookup(palette, grid_data);
            px_d       = '0;
            py_d       = '0;
            state_d    = S_DRAW;
            vga_plot_d = 1'b1;
            vga_x_d    = pix_x(cx_q, px_d);
            vga_y_d    = pix_y(cy_q, py_d);
            busy_d     = 1'b1;
         end
         S_DRAW: begin
            if (!tile_end_s) begin
               if (px_q == PX_LAST) begin
                  px_d = '0;
                  py_d = py_q + PY_ONE;
               end else begin
                  px_d = px_q + PX_ONE;
               end
               vga_plot_d = 1'b1;
               vga_x_d    = pix_x(cx_q, px_d);
               vga_y_d    = pix_y(cy_q, py_d);
               busy_d     = 1'b1;
            end else if (frame_end_s) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               if (cx_q == CX_LAST) begin
                  cx_d = '0;
                  cy_d = cy_q + CY_ONE;
               end else begin
                  cx_d = cx_q + CX_ONE;
               end
               state_d   = S_FETCH;
               grid_rd_d = 1'b1;
               grid_x_d  = cx_d;
               grid_y_d  = cy_d;
               busy_d    = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, counters and registered outputs; reset clears everything and abandons a frame.
   always_ff @(posedge clock_50) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         single_q   <= 1'b0;
         cx_q       <= '0;
         cy_q       <= '0;
         px_q       <= '0;
         py_q       <= '0;
         grid_x_q   <= '0;
         grid_y_q   <= '0;
         grid_rd_q  <= 1'b0;
         vga_x_q    <= '0;
         vga_y_q    <= '0;
         colour_q   <= '0;
         vga_plot_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         single_q   <= single_d;
         cx_q       <= cx_d;
         cy_q       <= cy_d;
         px_q       <= px_d;
         py_q       <= py_d;
         grid_x_q   <= grid_x_d;
         grid_y_q   <= grid_y_d;
         grid_rd_q  <= grid_rd_d;
         vga_x_q    <= vga_x_d;
         vga_y_q    <= vga_y_d;
         colour_q   <= colour_d;
         vga_plot_q <= vga_plot_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign grid_x   = grid_x_q;
   assign grid_y   = grid_y_q;
   assign grid_rd  = grid_rd_q;
   assign vga_x    = vga_x_q;
   assign vga_y    = vga_y_q;
   assign colour   = colour_q;
   assign vga_plot = vga_plot_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_map_tile_renderer.sv
// Directed bench for map_tile_renderer: reset, full redraw, single-cell redraw,
// out-of-range request, ignored start pulses and reset during a frame.
module tb_map_tile_renderer;

   logic        clock_50 = 1'b0;
   logic        resetn;
   logic        start;
   logic        single;
   logic [4:0]  req_x;
   logic [3:0]  req_y;
   logic [11:0] palette;
   logic [4:0]  grid_x;
   logic [3:0]  grid_y;
   logic        grid_rd;
   logic [1:0]  grid_data = 2'b00;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  colour;
   logic        vga_plot;
   logic        busy;
   logic        done;

   map_tile_renderer dut (
      .clock_50 (clock_50),
      .resetn   (resetn),
      .start    (start),
      .single   (single),
      .req_x    (req_x),
      .req_y    (req_y),
      .palette  (palette),
      .grid_x   (grid_x),
      .grid_y   (grid_y),
      .grid_rd  (grid_rd),
      .grid_data(grid_data),
      .vga_x    (vga_x),
      .vga_y    (vga_y),
      .colour   (colour),
      .vga_plot (vga_plot),
      .busy     (busy),
      .done     (done)
   );

   always #10 clock_50 = ~clock_50;

   // Grid store model: synchronous read port, data one cycle after the strobe.
   logic [1:0] mem [0:14][0:19];
   always @(posedge clock_50) begin
      if (grid_rd && grid_x < 5'd20 && grid_y < 4'd15) grid_data <= mem[grid_y][grid_x];
   end

   int errors = 0;
   int checks = 0;

   int n_rd, rd1_cyc, rd2_cyc, n_plot, plot1_cyc, n_done, done_cyc;
   int n_busy, n_busy_after, colour_diff, dup, outside, plots_after_rst;
   logic [4:0] rd1_x, rd2_x;
   logic [3:0] rd1_y, rd2_y;
   logic [7:0] plot1_x;
   logic [6:0] plot1_y;
   logic [2:0] colour1;
   bit busy_at_done, zero_after;
   bit cov [0:255][0:127];

   task automatic kick(input bit s, input logic [4:0] x, input logic [3:0] y);
      @(negedge clock_50);
      start = 1'b1; single = s; req_x = x; req_y = y;
   endtask

   // Watches outputs each cycle; cycle 1 is the first sample after the accepting edge.
   task automatic observe(input int max_cyc, input int extra, input int pulse_mid,
                          input bit pulse_done, input int rst_cyc,
                          input int x0, input int x1, input int y0, input int y1);
      n_rd = 0; rd1_cyc = 0; rd2_cyc = 0; n_plot = 0; plot1_cyc = 0; n_done = 0; done_cyc = 0;
      n_busy = 0; n_busy_after = 0; colour_diff = 0; dup = 0; outside = 0; plots_after_rst = 0;
      rd1_x = '0; rd2_x = '0; rd1_y = '0; rd2_y = '0; plot1_x = '0; plot1_y = '0; colour1 = '0;
      busy_at_done = 1'b0; zero_after = 1'b0;
      for (int i = 0; i < 256; i++) for (int j = 0; j < 128; j++) cov[i][j] = 1'b0;
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         @(negedge clock_50);
         if (grid_rd) begin
            n_rd++;
            if (n_rd == 1) begin rd1_cyc = cyc; rd1_x = grid_x; rd1_y = grid_y; end
            else if (n_rd == 2) begin rd2_cyc = cyc; rd2_x = grid_x; rd2_y = grid_y; end
         end
         if (vga_plot) begin
            n_plot++;
            if (n_plot == 1) begin plot1_cyc = cyc; plot1_x = vga_x; plot1_y = vga_y; colour1 = colour; end
            else if (colour !== colour1) colour_diff++;
            if (rst_cyc != 0 && cyc > rst_cyc) plots_after_rst++;
            if (int'(vga_x) < x0 || int'(vga_x) > x1 || int'(vga_y) < y0 || int'(vga_y) > y1) outside++;
            else if (cov[vga_x][vga_y]) dup++;
            else cov[vga_x][vga_y] = 1'b1;
         end
         if (busy) begin
            n_busy++;
            if (n_done > 0) n_busy_after++;
         end
         if (done) begin
            n_done++;
            if (n_done == 1) begin done_cyc = cyc; busy_at_done = busy; end
         end
         if (rst_cyc != 0 && cyc == rst_cyc + 1)
            zero_after = ({grid_x, grid_y, grid_rd, vga_x, vga_y, colour, vga_plot, busy, done} == '0);
         start  = (cyc == pulse_mid) || (pulse_done && done);
         resetn = !(rst_cyc != 0 && cyc >= rst_cyc && cyc < rst_cyc + 5);
         if (n_done > 0 && cyc >= done_cyc + extra) break;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0; start = 1'b0; single = 1'b0; req_x = '0; req_y = '0;
      repeat (5) @(posedge clock_50);
      @(negedge clock_50);
      checks++; if ({grid_rd, vga_plot, done, busy} !== 4'b0000) begin errors++;
         $display("FAIL reset_strobes: got %b expected 0000", {grid_rd, vga_plot, done, busy}); end
      checks++; if ({grid_x, grid_y} !== 9'd0) begin errors++;
         $display("FAIL reset_grid_xy: got %0d,%0d expected 0,0", grid_x, grid_y); end
      checks++; if ({vga_x, vga_y, colour} !== 18'd0) begin errors++;
         $display("FAIL reset_vga: got x=%0d y=%0d c=%b expected 0", vga_x, vga_y, colour); end
      resetn = 1'b1;
      observe(10, 0, 0, 1'b0, 0, 0, 159, 0, 119);
      checks++; if (n_rd + n_plot + n_done + n_busy !== 0) begin errors++;
         $display("FAIL idle_quiet: got rd=%0d plot=%0d done=%0d busy=%0d expected all 0",
                  n_rd, n_plot, n_done, n_busy); end
   endtask

   task automatic test_full();
      kick(1'b0, 5'd0, 4'd0);
      observe(20000, 3, 0, 1'b0, 0, 0, 159, 0, 119);
      checks++; if (n_rd !== 300) begin errors++; $display("FAIL full_rd_count: got %0d expected 300", n_rd); end
      checks++; if (rd1_cyc !== 1 || rd1_x !== 5'd0 || rd1_y !== 4'd0) begin errors++;
         $display("FAIL full_rd1: got cyc=%0d (%0d,%0d) expected cyc=1 (0,0)", rd1_cyc, rd1_x, rd1_y); end
      checks++; if (rd2_cyc !== 67 || rd2_x !== 5'd1 || rd2_y !== 4'd0) begin errors++;
         $display("FAIL full_rd2: got cyc=%0d (%0d,%0d) expected cyc=67 (1,0)", rd2_cyc, rd2_x, rd2_y); end
      checks++; if (plot1_cyc !== 3 || plot1_x !== 8'd0 || plot1_y !== 7'd0) begin errors++;
         $display("FAIL full_plot1: got cyc=%0d (%0d,%0d) expected cyc=3 (0,0)", plot1_cyc, plot1_x, plot1_y); end
      checks++; if (colour1 !== 3'b010 || colour_diff !== 0) begin errors++;
         $display("FAIL full_colour: got %b diff=%0d expected 010 diff=0", colour1, colour_diff); end
      checks++; if (n_plot !== 19200 || dup !== 0 || outside !== 0) begin errors++;
         $display("FAIL full_coverage: got plots=%0d dup=%0d out=%0d expected 19200 0 0", n_plot, dup, outside); end
      checks++; if (done_cyc !== 19801 || n_done !== 1) begin errors++;
         $display("FAIL full_done: got cyc=%0d count=%0d expected cyc=19801 count=1", done_cyc, n_done); end
      checks++; if (busy_at_done !== 1'b0 || n_busy_after !== 0 || n_busy !== 19800) begin errors++;
         $display("FAIL full_busy: got at_done=%0d after=%0d total=%0d expected 0 0 19800",
                  busy_at_done, n_busy_after, n_busy); end
   endtask

   task automatic test_single();
      kick(1'b1, 5'd5, 4'd3);
      observe(200, 3, 0, 1'b0, 0, 40, 47, 24, 31);
      checks++; if (n_rd !== 1 || rd1_cyc !== 1 || rd1_x !== 5'd5 || rd1_y !== 4'd3) begin errors++;
         $display("FAIL single_rd: got n=%0d cyc=%0d (%0d,%0d) expected 1 1 (5,3)", n_rd, rd1_cyc, rd1_x, rd1_y); end
      checks++; if (n_plot !== 64 || dup !== 0 || outside !== 0) begin errors++;
         $display("FAIL single_coverage: got plots=%0d dup=%0d out=%0d expected 64 0 0", n_plot, dup, outside); end
      checks++; if (plot1_cyc !== 3 || plot1_x !== 8'd40 || plot1_y !== 7'd24) begin errors++;
         $display("FAIL single_plot1: got cyc=%0d (%0d,%0d) expected cyc=3 (40,24)", plot1_cyc, plot1_x, plot1_y); end
      checks++; if (colour1 !== 3'b100 || colour_diff !== 0) begin errors++;
         $display("FAIL single_colour: got %b diff=%0d expected 100 diff=0", colour1, colour_diff); end
      checks++; if (done_cyc !== 67 || n_done !== 1 || busy_at_done !== 1'b0) begin errors++;
         $display("FAIL single_done: got cyc=%0d count=%0d busy=%0d expected 67 1 0", done_cyc, n_done, busy_at_done); end
   endtask

   task automatic test_out_of_range();
      kick(1'b1, 5'd20, 4'd3);
      observe(50, 3, 0, 1'b0, 0, 0, 159, 0, 119);
      checks++; if (n_rd !== 0 || n_plot !== 0 || n_busy !== 0) begin errors++;
         $display("FAIL oor_quiet: got rd=%0d plot=%0d busy=%0d expected 0 0 0", n_rd, n_plot, n_busy); end
      checks++; if (done_cyc !== 1 || n_done !== 1) begin errors++;
         $display("FAIL oor_done: got cyc=%0d count=%0d expected 1 1", done_cyc, n_done); end
   endtask

   task automatic test_back_to_back();
      kick(1'b1, 5'd5, 4'd3);
      observe(200, 10, 20, 1'b1, 0, 40, 47, 24, 31);
      checks++; if (n_done !== 1 || done_cyc !== 67) begin errors++;
         $display("FAIL ignore_done: got count=%0d cyc=%0d expected 1 67", n_done, done_cyc); end
      checks++; if (n_rd !== 1 || n_plot !== 64 || n_busy_after !== 0) begin errors++;
         $display("FAIL ignore_activity: got rd=%0d plot=%0d busy_after=%0d expected 1 64 0",
                  n_rd, n_plot, n_busy_after); end
   endtask

   task automatic test_reset_mid();
      kick(1'b0, 5'd0, 4'd0);
      observe(730, 0, 0, 1'b0, 700, 0, 159, 0, 119);
      checks++; if (zero_after !== 1'b1) begin errors++;
         $display("FAIL midrst_outputs: got zero=%0d expected 1", zero_after); end
      checks++; if (n_rd !== 11 || n_done !== 0 || plots_after_rst !== 0) begin errors++;
         $display("FAIL midrst_abort: got rd=%0d done=%0d plots_after=%0d expected 11 0 0",
                  n_rd, n_done, plots_after_rst); end
      kick(1'b0, 5'd0, 4'd0);
      observe(20000, 2, 0, 1'b0, 0, 0, 159, 0, 119);
      checks++; if (rd1_cyc !== 1 || rd1_x !== 5'd0 || rd1_y !== 4'd0) begin errors++;
         $display("FAIL restart_rd1: got cyc=%0d (%0d,%0d) expected cyc=1 (0,0)", rd1_cyc, rd1_x, rd1_y); end
      checks++; if (done_cyc !== 19801 || n_done !== 1 || n_plot !== 19200 || dup !== 0) begin errors++;
         $display("FAIL restart_frame: got done=%0d count=%0d plots=%0d dup=%0d expected 19801 1 19200 0",
                  done_cyc, n_done, n_plot, dup); end
   endtask

   initial begin
      palette = {3'b111, 3'b100, 3'b010, 3'b001};
      for (int y = 0; y < 15; y++) for (int x = 0; x < 20; x++) mem[y][x] = 2'd1;
      test_reset();
      test_full();
      mem[3][5] = 2'd2;
      test_single();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
